motor_step_scheduler: RTL and testbench

Command-driven sequencer for the four-phase stepper driver. It accepts move commands over a valid/ready handshake, each giving a step count and a step period in clocks. For each command it asserts the driver's enable and issues exactly one single-cycle step-advance pulse per step at the commanded rate. It also supports hold (pause) and abort, and reports completion. It sits between the CPU-side peripheral registers and the stepper phase driver, whose `en`/`clkEn` inputs it drives.

---
 rtl/motor_step_scheduler.sv | 103 ++++++++++
 tb/tb_motor_step_scheduler.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/motor_step_scheduler.sv
// motor_step_scheduler: accepts move commands and drives the stepper phase
// driver with an enable and one single-cycle step pulse per step at the
// commanded period. Supports hold (pause), abort and a completion pulse.
module motor_step_scheduler #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             hold,
  input  logic             abort,
  output logic             motor_en,
  output logic             motor_clk_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] timer;
  logic [DIV_W-1:0] period_q;
  logic             abort_q;
  logic [DIV_W-1:0] period_eff;
  logic             last_step;

  // A period of zero behaves as one clock per step
  assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;

  // Step pulse: due whenever the timer has expired and we are not paused
  assign motor_clk_en = (state == S_RUN) && (timer == '0) && !hold;
  assign last_step    = motor_clk_en && (steps_left == CNT_W'(1));

  // Outputs decoded from registered state; only cmd_ready sees rst directly
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign motor_en  = (state == S_RUN);
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign aborted   = (state == S_DONE) && abort_q;

  // Sequencer: command accept, step timing, hold/abort and completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      timer      <= '0;
      period_q   <= '0;
      steps_left <= '0;
      abort_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            steps_left <= cmd_steps;
            abort_q    <= 1'b0;
            if (cmd_steps == '0) begin
              state <= S_DONE;
            end else begin
              period_q <= period_eff;
              timer    <= period_eff - DIV_W'(1);
              state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (timer == '0) begin
              steps_left <= steps_left - CNT_W'(1);
              timer      <= period_q - DIV_W'(1);
              if (steps_left == CNT_W'(1)) begin
                state <= S_DONE;
              end
            end else begin
              timer <= timer - DIV_W'(1);
            end
          end
          // Normal completion on the same cycle takes precedence over abort
          if (abort && !last_step) begin
            state   <= S_DONE;
            abort_q <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          abort_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_step_scheduler.sv
// tb_motor_step_scheduler: directed, table-driven check of motor_step_scheduler.
module tb_motor_step_scheduler;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIV_W = 16;
  localparam int unsigned NVEC  = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_period;
  logic             hold;
  logic             abort;
  logic             motor_en;
  logic             motor_clk_en;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] steps_left;

  motor_step_scheduler #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_steps    (cmd_steps),
    .cmd_period   (cmd_period),
    .hold         (hold),
    .abort        (abort),
    .motor_en     (motor_en),
    .motor_clk_en (motor_clk_en),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .steps_left   (steps_left)
  );

  always #5 clk = ~clk;

  // One move: inputs plus expected per-cycle behaviour (cycle 0 = accept)
  typedef struct {
    int          n;
    int          p;
    int          hold_lo;
    int          hold_hi;
    int          abort_c;
    int          rst_c;
    logic [63:0] mask;      // bit c set => step pulse expected in cycle c
    int          done_c;    // -1 => no done pulse
    int          exp_ab;
    int          exp_left;
    int          run_last;  // motor_en/busy high in cycles 1..run_last
    int          ready_c;   // cmd_ready returns in this cycle
  } vec_t;

  vec_t vecs[NVEC];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    // N=3 P=4
    vecs[0] = '{3, 4, 0, -1, -1, -1, (64'd1<<4)|(64'd1<<8)|(64'd1<<12), 13, 0, 0, 12, 14};
    // N=2 P=0 (treated as 1)
    vecs[1] = '{2, 0, 0, -1, -1, -1, (64'd1<<1)|(64'd1<<2), 3, 0, 0, 2, 4};
    // N=0 P=5: no motor activity
    vecs[2] = '{0, 5, 0, -1, -1, -1, 64'd0, 1, 0, 0, 0, 2};
    // N=5 P=2 hold in cycles 3..5
    vecs[3] = '{5, 2, 3, 5, -1, -1, (64'd1<<2)|(64'd1<<7)|(64'd1<<9)|(64'd1<<11)|(64'd1<<13), 14, 0, 0, 13, 15};
    // N=10 P=3 abort in cycle 7
    vecs[4] = '{10, 3, 0, -1, 7, -1, (64'd1<<3)|(64'd1<<6), 8, 1, 8, 7, 9};
    // N=10 P=2 reset in cycle 5: no done, idle in cycle 6
    vecs[5] = '{10, 2, 0, -1, -1, 5, (64'd1<<2)|(64'd1<<4), -1, 0, 0, 5, 6};
    // N=2 P=2 abort on the last pulse: normal completion wins
    vecs[6] = '{2, 2, 0, -1, 4, -1, (64'd1<<2)|(64'd1<<4), 5, 0, 0, 4, 6};
    // N=3 P=1 abort while holding a due pulse: pulse suppressed
    vecs[7] = '{3, 1, 2, 2, 2, -1, (64'd1<<1), 3, 1, 2, 2, 4};
    // N=1 P=1 abort during DONE is ignored
    vecs[8] = '{1, 1, 0, -1, 2, -1, (64'd1<<1), 2, 0, 0, 1, 3};

    rst = 1'b1; cmd_valid = 1'b0; cmd_steps = '0; cmd_period = '0; hold = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    #1 chk("ready_in_rst", 0, 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_motor_en", 0, 32'(motor_en), 32'd0);
    chk("rst_clk_en", 0, 32'(motor_clk_en), 32'd0);
    chk("rst_busy", 0, 32'(busy), 32'd0);
    chk("rst_done", 0, 32'(done), 32'd0);
    chk("rst_aborted", 0, 32'(aborted), 32'd0);
    chk("rst_steps_left", 0, 32'(steps_left), 32'd0);
    chk("rst_ready", 0, 32'(cmd_ready), 32'd1);

    // hold/abort in IDLE must not disturb anything
    hold = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    hold = 1'b0; abort = 1'b0;
    #1;
    chk("idle_ignore_ready", 0, 32'(cmd_ready), 32'd1);
    chk("idle_ignore_done", 0, 32'(done), 32'd0);

    for (int v = 0; v < int'(NVEC); v++) begin
      cmd_steps  = CNT_W'(vecs[v].n);
      cmd_period = DIV_W'(vecs[v].p);
      cmd_valid  = 1'b1;
      hold = 1'b0; abort = 1'b0; rst = 1'b0;
      #1 chk($sformatf("v%0d_accept_ready", v), 0, 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      for (int c = 1; c <= vecs[v].ready_c; c++) begin
        hold  = (c >= vecs[v].hold_lo) && (c <= vecs[v].hold_hi);
        abort = (c == vecs[v].abort_c);
        rst   = (c == vecs[v].rst_c);
        #1;
        chk($sformatf("v%0d_clk_en", v), c, 32'(motor_clk_en), 32'(vecs[v].mask[c]));
        chk($sformatf("v%0d_done", v), c, 32'(done), 32'(c == vecs[v].done_c));
        chk($sformatf("v%0d_motor_en", v), c, 32'(motor_en), 32'(c <= vecs[v].run_last));
        chk($sformatf("v%0d_busy", v), c, 32'(busy), 32'(c <= vecs[v].run_last));
        chk($sformatf("v%0d_ready", v), c, 32'(cmd_ready), 32'(c >= vecs[v].ready_c));
        if (c == vecs[v].done_c) begin
          chk($sformatf("v%0d_aborted", v), c, 32'(aborted), 32'(vecs[v].exp_ab));
          chk($sformatf("v%0d_left_at_done", v), c, 32'(steps_left), 32'(vecs[v].exp_left));
        end else begin
          chk($sformatf("v%0d_aborted_idle", v), c, 32'(aborted), 32'd0);
        end
        if (vecs[v].rst_c > 0 && c == vecs[v].rst_c + 1) begin
          chk($sformatf("v%0d_left_after_rst", v), c, 32'(steps_left), 32'd0);
        end
        if (c < vecs[v].ready_c) begin
          @(posedge clk); #1;
        end
      end
      hold = 1'b0; abort = 1'b0; rst = 1'b0;
    end

    // steps_left countdown for N=3 P=4: 3, 2, 1, 0 after each pulse
    cmd_steps = CNT_W'(3); cmd_period = DIV_W'(4); cmd_valid = 1'b1;
    #1 chk("cnt_accept_ready", 0, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      #1;
      if (c == 1)  chk("cnt_left", c, 32'(steps_left), 32'd3);
      if (c == 4)  chk("cnt_left", c, 32'(steps_left), 32'd3);
      if (c == 5)  chk("cnt_left", c, 32'(steps_left), 32'd2);
      if (c == 9)  chk("cnt_left", c, 32'(steps_left), 32'd1);
      if (c == 13) chk("cnt_left", c, 32'(steps_left), 32'd0);
      if (c == 14) chk("cnt_ready", c, 32'(cmd_ready), 32'd1);
      if (c < 14) begin
        @(posedge clk); #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
